// File: rtl/hcla_digit_sequencer.sv
// hcla_digit_sequencer: WIDTH-bit adder that reuses one 2-bit hybrid CLA slice per radix-4 digit.
// Optional build macro HCLA_DIGIT_SEQUENCER_SUB_EN adds a SUB port for A-B.

module hcla_slice2 (
    input  logic [1:0] a,
    input  logic [1:0] b,
    input  logic       ci,
    output logic [1:0] s,
    output logic       co
);
    logic [1:0] g;
    logic [1:0] p;
    logic       c1;
    assign g  = a & b;
    assign p  = a ^ b;
    assign c1 = g[0] | (p[0] & ci);
    assign co = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    assign s  = p ^ {c1, ci};
endmodule

module hcla_digit_sequencer #(
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef HCLA_DIGIT_SEQUENCER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout
);
    localparam int N  = WIDTH / 2;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_next;
    logic             c_q;
    logic [CW-1:0]    cnt_q;
    logic [1:0]       sum2;
    logic             co;
    logic             accept;
    logic             last;
    logic             sub_in;

`ifdef HCLA_DIGIT_SEQUENCER_SUB_EN
    assign sub_in = sub;
`else
    assign sub_in = 1'b0;
`endif

    assign accept = start && (state_q != ST_RUN);
    assign last   = cnt_q == CW'(N - 1);

    hcla_slice2 u_slice (
        .a  (a_q[1:0]),
        .b  (b_q[1:0]),
        .ci (c_q),
        .s  (sum2),
        .co (co)
    );

    // New digit enters the result register from the MSB end.
    if (WIDTH == 2) begin : g_res_w2
        assign res_next = sum2;
    end else begin : g_res_wn
        assign res_next = {sum2, res_q[WIDTH-1:2]};
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next state: abort beats the final digit; DONE accepts a new start like IDLE.
    always_comb begin
        state_d = (state_q == ST_RUN) ? (abort ? ST_IDLE : (last ? ST_DONE : ST_RUN))
                                      : (start ? ST_RUN : ST_IDLE);
    end

    // Handshake outputs decoded from state.
    always_comb begin
        busy = state_q == ST_RUN;
        done = state_q == ST_DONE;
    end

    // Datapath: load on accept, one digit per RUN cycle, publish S/COUT only on a clean exit.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            res_q <= '0;
            c_q   <= 1'b0;
            cnt_q <= '0;
            s     <= '0;
            cout  <= 1'b0;
        end else if (accept) begin
            a_q   <= a;
            b_q   <= sub_in ? ~b : b;
            c_q   <= sub_in | cin;
            cnt_q <= '0;
        end else if (state_q == ST_RUN) begin
            a_q   <= a_q >> 2;
            b_q   <= b_q >> 2;
            res_q <= res_next;
            c_q   <= co;
            cnt_q <= cnt_q + CW'(1);
            if (last && !abort) begin
                s    <= res_next;
                cout <= co;
            end
        end
    end
endmodule

// File: tb/tb_hcla_digit_sequencer.sv
// tb_hcla_digit_sequencer: table, corner-sequence and random checks at WIDTH 8, 2 and 24.
module tb_hcla_digit_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic start8, abort8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, s8;
    logic start24, abort24, cin24, busy24, done24, cout24;
    logic [23:0] a24, b24, s24;
    logic start2, abort2, cin2, busy2, done2, cout2;
    logic [1:0] a2, b2, s2;
`ifdef HCLA_DIGIT_SEQUENCER_SUB_EN
    logic sub8 = 1'b0, sub24 = 1'b0, sub2 = 1'b0;
`endif

    hcla_digit_sequencer #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .abort(abort8), .a(a8), .b(b8), .cin(cin8),
`ifdef HCLA_DIGIT_SEQUENCER_SUB_EN
        .sub(sub8),
`endif
        .busy(busy8), .done(done8), .s(s8), .cout(cout8));

    hcla_digit_sequencer #(.WIDTH(24)) dut24 (
        .clk(clk), .rst(rst), .start(start24), .abort(abort24), .a(a24), .b(b24), .cin(cin24),
`ifdef HCLA_DIGIT_SEQUENCER_SUB_EN
        .sub(sub24),
`endif
        .busy(busy24), .done(done24), .s(s24), .cout(cout24));

    hcla_digit_sequencer #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .abort(abort2), .a(a2), .b(b2), .cin(cin2),
`ifdef HCLA_DIGIT_SEQUENCER_SUB_EN
        .sub(sub2),
`endif
        .busy(busy2), .done(done2), .s(s2), .cout(cout2));

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] s;
        logic       cout;
    } vec_t;
    vec_t tbl[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic tc, input logic ts,
                       input logic ab, input logic [7:0] es, input logic ec, input string nm);
        int lat;
        int nb;
        a8 = ta; b8 = tb; cin8 = tc; abort8 = ab; start8 = 1'b1;
`ifdef HCLA_DIGIT_SEQUENCER_SUB_EN
        sub8 = ts;
`endif
        tick;
        start8 = 1'b0; abort8 = 1'b0;
        lat = 0; nb = 0;
        while (!done8 && lat < 20) begin
            if (busy8) nb++;
            tick;
            lat++;
        end
        chk({nm, " latency"}, lat, 4);
        chk({nm, " busy_cycles"}, nb, 4);
        chk({nm, " s"}, s8, es);
        chk({nm, " cout"}, cout8, ec);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [31:0] ra, rb, rc;
        logic [24:0] exp24;
        tbl[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        tbl[1] = '{8'h5A, 8'h3C, 1'b1, 8'h97, 1'b0};
        tbl[2] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        tbl[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        tbl[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        tbl[5] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
        tbl[6] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};

        rst = 1'b1;
        {start8, abort8, cin8, a8, b8} = '0;
        {start24, abort24, cin24, a24, b24} = '0;
        {start2, abort2, cin2, a2, b2} = '0;
        repeat (2) tick;
        rst = 1'b0;
        tick;
        chk("reset s", s8, 0);
        chk("reset cout", cout8, 0);
        chk("reset busy", busy8, 0);
        chk("reset done", done8, 0);
        chk("reset s24", s24, 0);
        for (int i = 0; i < 10; i++) begin
            tick;
            chk("idle done", done8, 0);
        end

        op8(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, "ripple");
        for (int i = 0; i < 10; i++) begin
            tick;
            chk("ripple hold s", s8, 8'h00);
        end

        a8 = 8'h5A; b8 = 8'h3C; cin8 = 1'b1; start8 = 1'b1;
        tick;
        a8 = 8'h11; b8 = 8'h22; cin8 = 1'b0;
        lat = 0;
        while (!done8 && lat < 20) begin tick; lat++; end
        chk("b2b first latency", lat, 4);
        chk("b2b first s", s8, 8'h97);
        chk("b2b first cout", cout8, 0);
        a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0;
        tick;
        start8 = 1'b0;
        chk("b2b accept busy", busy8, 1);
        lat = 0;
        while (!done8 && lat < 20) begin tick; lat++; end
        chk("b2b second latency", lat, 4);
        chk("b2b second s", s8, 8'h00);
        chk("b2b second cout", cout8, 1);
        tick;

        a8 = 8'h0F; b8 = 8'h01; start8 = 1'b1;
        tick;
        start8 = 1'b0;
        tick;
        abort8 = 1'b1;
        tick;
        abort8 = 1'b0;
        chk("abort busy", busy8, 0);
        chk("abort done", done8, 0);
        chk("abort s", s8, 8'h00);
        chk("abort cout", cout8, 1);
        for (int i = 0; i < 6; i++) begin
            tick;
            chk("abort no done", done8, 0);
        end

        a8 = 8'h33; b8 = 8'h44; start8 = 1'b1;
        tick;
        start8 = 1'b0;
        repeat (3) tick;
        chk("abort_exit busy", busy8, 1);
        abort8 = 1'b1;
        tick;
        abort8 = 1'b0;
        chk("abort_exit done", done8, 0);
        chk("abort_exit busy after", busy8, 0);
        chk("abort_exit s", s8, 8'h00);
        chk("abort_exit cout", cout8, 1);

        op8(8'h01, 8'h01, 1'b0, 1'b0, 1'b1, 8'h02, 1'b0, "abort_idle");
        op8(8'hF0, 8'h1F, 1'b1, 1'b0, 1'b0, 8'h10, 1'b1, "pre_rst");
        tick;
        a8 = 8'hF0; b8 = 8'h0F; start8 = 1'b1;
        tick;
        start8 = 1'b0;
        repeat (2) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("midrst s", s8, 0);
        chk("midrst cout", cout8, 0);
        chk("midrst busy", busy8, 0);
        chk("midrst done", done8, 0);
        tick;

        for (int i = 0; i < 7; i++)
            op8(tbl[i].a, tbl[i].b, tbl[i].cin, 1'b0, 1'b0, tbl[i].s, tbl[i].cout, $sformatf("tbl%0d", i));

`ifdef HCLA_DIGIT_SEQUENCER_SUB_EN
        op8(8'h10, 8'h01, 1'b0, 1'b1, 1'b0, 8'h0F, 1'b1, "sub_ge");
        op8(8'h01, 8'h02, 1'b0, 1'b1, 1'b0, 8'hFF, 1'b0, "sub_lt");
        op8(8'h10, 8'h01, 1'b1, 1'b1, 1'b0, 8'h0F, 1'b1, "sub_cin_ignored");
        op8(8'h10, 8'h01, 1'b0, 1'b0, 1'b0, 8'h11, 1'b0, "sub0_add");
`endif

        a2 = 2'd3; b2 = 2'd3; cin2 = 1'b1; start2 = 1'b1;
        tick;
        start2 = 1'b0;
        lat = 0;
        while (!done2 && lat < 20) begin tick; lat++; end
        chk("w2 latency", lat, 1);
        chk("w2 s", s2, 3);
        chk("w2 cout", cout2, 1);

        for (int i = 0; i < 1000; i++) begin
            ra = $urandom; rb = $urandom; rc = $urandom;
            a24 = (i == 0) ? 24'hFFFFFF : (i == 1) ? 24'h0 : ra[23:0];
            b24 = (i == 0) ? 24'hFFFFFF : (i == 1) ? 24'h0 : rb[23:0];
            cin24 = (i == 0) ? 1'b1 : (i == 1) ? 1'b0 : rc[0];
            exp24 = {1'b0, a24} + {1'b0, b24} + {24'd0, cin24};
            start24 = 1'b1;
            tick;
            start24 = 1'b0;
            lat = 0;
            while (!done24 && lat < 40) begin tick; lat++; end
            chk("w24 latency", lat, 12);
            chk("w24 sum", {cout24, s24}, exp24);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
